// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream with two internal line buffers.
// Latency: a pixel accepted in cycle t produces its window result in cycle t+3 (S1 products, S2 sum, S3 scale/clamp).
// Backpressure: none; the pipeline never stalls, and input gaps appear as gaps in pix_out_valid.
//
// Ports:
//   clk, rst                          rising-edge clock, asynchronous active-high reset
//   pix_in, pix_valid, sof            input pixel, its qualifier, start-of-frame (qualified by pix_valid)
//   coef_we, coef_addr, coef_data     coefficient write port; index 0..8 in raster order, 4 = centre
//   pix_out, pix_out_valid            scaled and saturated result, one-cycle valid pulse per window
//   window_ok                         high while two full lines of the current frame are buffered
//   frame_done                        one-cycle pulse after the last pixel of a frame is accepted
module conv3x3_stream #(
    parameter int PW    = 8,
    parameter int CW    = 8,
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic [PW-1:0] pix_out,
    output logic          pix_out_valid,
    output logic          window_ok,
    output logic          frame_done
);

    localparam int CLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RLW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PRW = PW + CW + 1;   // one signed product
    localparam int SW  = PW + CW + 5;   // sum of nine products, cannot overflow

    localparam logic [CLW-1:0]       COL_LAST = CLW'(IMG_W - 1);
    localparam logic [RLW-1:0]       ROW_LAST = RLW'(IMG_H - 1);
    localparam logic [CLW-1:0]       COL_ONE  = CLW'(1);
    localparam logic [RLW-1:0]       ROW_ONE  = RLW'(1);
    localparam logic [CLW-1:0]       COL_TWO  = CLW'(2);
    localparam logic [RLW-1:0]       ROW_TWO  = RLW'(2);
    localparam logic signed [SW-1:0] SAT_MAX  = SW'((1 << PW) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Control: acceptance, position of the accepted pixel, FSM
    // ------------------------------------------------------------------
    state_t         state_q;
    logic [RLW-1:0] row_q;
    logic [CLW-1:0] col_q;
    logic           window_ok_q;
    logic           frame_done_q;

    logic           acc;
    logic [RLW-1:0] cur_row;
    logic [CLW-1:0] cur_col;
    logic           last_col;
    logic           last_pix;
    logic           win_vld;

    always_comb begin
        // Outside a frame only a start-of-frame pixel is taken.
        acc      = pix_valid && (sof || (state_q != IDLE));
        // A start-of-frame pixel is always (0,0), whatever the counters hold.
        cur_row  = sof ? '0 : row_q;
        cur_col  = sof ? '0 : col_q;
        last_col = (cur_col == COL_LAST);
        last_pix = last_col && (cur_row == ROW_LAST);
        win_vld  = acc && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            window_ok_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (acc) begin
                col_q <= last_col ? '0 : cur_col + COL_ONE;
                row_q <= last_col ? cur_row + ROW_ONE : cur_row;
                if (sof) begin
                    state_q     <= FILL;
                    window_ok_q <= 1'b0;
                end else if ((state_q == FILL) && (cur_row == ROW_TWO) && (cur_col == '0)) begin
                    state_q     <= STREAM;
                    window_ok_q <= 1'b1;
                end else if ((state_q == STREAM) && last_pix) begin
                    state_q      <= IDLE;
                    window_ok_q  <= 1'b0;
                    frame_done_q <= 1'b1;
                    row_q        <= '0;
                    col_q        <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficients (identity after reset)
    // ------------------------------------------------------------------
    logic signed [CW-1:0] coef_q [9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                coef_q[k] <= (k == 4) ? CW'(1) : '0;
            end
        end else if (coef_we && (coef_addr <= 4'd8)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and column history (not reset: refilled after every sof)
    // lb0 holds row r-1, lb1 holds row r-2, both indexed by column.
    // ------------------------------------------------------------------
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] c1_q [3];      // column c-1, index 0 = top row
    logic [PW-1:0] c2_q [3];      // column c-2
    logic [PW-1:0] col_cur [3];   // column c, including the incoming pixel

    always_comb begin
        col_cur[0] = lb1[cur_col];
        col_cur[1] = lb0[cur_col];
        col_cur[2] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= pix_in;
            c2_q         <= c1_q;
            c1_q         <= col_cur;
        end
    end

    // ------------------------------------------------------------------
    // S1: window products. Products use the coefficients as registered,
    // so a write landing on the same edge only affects later windows.
    // ------------------------------------------------------------------
    logic [PW-1:0]         win [9];
    logic signed [PRW-1:0] prod_d [9];
    logic signed [PRW-1:0] prod_q [9];
    logic                  s1_vld_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win[3*i]     = c2_q[i];
            win[3*i + 1] = c1_q[i];
            win[3*i + 2] = col_cur[i];
        end
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = PRW'($signed({1'b0, win[k]})) * PRW'(coef_q[k]);
        end
    end

    // S2: adder tree
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic                 s2_vld_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + SW'(prod_q[k]);
        end
    end

    // S3: arithmetic shift then clamp to the unsigned pixel range
    logic signed [SW-1:0] shifted;
    logic [PW-1:0]        sat_d;
    logic [PW-1:0]        pix_out_q;
    logic                 pix_out_valid_q;

    always_comb begin
        shifted = sum_q >>> SHIFT;
        if (shifted < 0) begin
            sat_d = '0;
        end else if (shifted > SAT_MAX) begin
            sat_d = '1;
        end else begin
            sat_d = shifted[PW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= '0;
            end
            s1_vld_q        <= 1'b0;
            sum_q           <= '0;
            s2_vld_q        <= 1'b0;
            pix_out_q       <= '0;
            pix_out_valid_q <= 1'b0;
        end else begin
            s1_vld_q <= win_vld;
            if (win_vld) begin
                prod_q <= prod_d;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                sum_q <= sum_d;
            end
            pix_out_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                pix_out_q <= sat_d;
            end
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign window_ok     = window_ok_q;
    assign frame_done    = frame_done_q;

endmodule
